// File: rtl/mc_sequencer_pkg.sv
// Shared state encodings, RV32 major opcodes and strobe bundle for the
// multi-cycle control sequencer.
package mc_sequencer_pkg;

    localparam logic [2:0] ST_FETCH     = 3'd0;
    localparam logic [2:0] ST_DECODE    = 3'd1;
    localparam logic [2:0] ST_EXECUTE   = 3'd2;
    localparam logic [2:0] ST_MEMORY    = 3'd3;
    localparam logic [2:0] ST_WRITEBACK = 3'd4;
    localparam logic [2:0] ST_HALT      = 3'd5;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic mem_req;
        logic mem_we;
        logic addr_sel;
        logic ir_we;
        logic pc_we;
        logic rf_we;
    } strobes_t;

    function automatic logic opc_supported(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM, OPC_LUI,
            OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_FENCE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_sequencer_wait_timer.sv
// Saturating wait-state counter; expired flags the stalled request cycle
// whose increment would reach LIMIT, so the caller can abort on that edge.
module wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign expired = en && (cnt_q == W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && (cnt_q != W'(LIMIT)))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer over one
// handshaked memory port, with retire/cycle counters and sticky error flags.
module mc_sequencer
    import mc_sequencer_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic             rf_we,
    output logic [2:0]       state,
    output logic             halted,
    output logic             bus_err,
    output logic             illegal,
    output logic [CNT_W-1:0] instret,
    output logic [CNT_W-1:0] cycles
);
    logic [2:0]       state_q, state_d;
    logic             bus_err_q, bus_err_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    strobes_t         stb;
    logic             timeout;

    // Waits are counted only while a request is stalled; any idle or ack cycle rearms it.
    wait_timer #(.LIMIT(MEM_TIMEOUT)) u_wait (
        .clk     (clk),
        .rst     (rst),
        .clr     (!stb.mem_req || mem_ack),
        .en      (stb.mem_req && !mem_ack),
        .expired (timeout)
    );

    always_comb begin
        stb       = '0;
        state_d   = state_q;
        bus_err_d = bus_err_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_FETCH: begin
                stb.mem_req = 1'b1;
                if (mem_ack) begin
                    stb.ir_we = 1'b1;
                    state_d   = ST_DECODE;
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_HALT;
                end
            end
            ST_DECODE: begin
                if (opcode == OPC_SYSTEM) begin
                    state_d = ST_HALT;
                end else if (!opc_supported(opcode)) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                case (opcode)
                    OPC_LOAD, OPC_STORE: state_d = ST_MEMORY;
                    OPC_BRANCH, OPC_FENCE: begin
                        stb.pc_we = 1'b1;
                        state_d   = ST_FETCH;
                    end
                    default: state_d = ST_WRITEBACK;
                endcase
            end
            ST_MEMORY: begin
                stb.mem_req  = 1'b1;
                stb.addr_sel = 1'b1;
                stb.mem_we   = (opcode == OPC_STORE);
                if (mem_ack) begin
                    if (opcode == OPC_STORE) begin
                        stb.pc_we = 1'b1;
                        state_d   = ST_FETCH;
                    end else begin
                        state_d = ST_WRITEBACK;
                    end
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_HALT;
                end
            end
            ST_WRITEBACK: begin
                stb.rf_we = 1'b1;
                stb.pc_we = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_HALT: ;
            default: state_d = ST_HALT;
        endcase

        if (!rst) begin
            stb.mem_req = 1'b0;
            stb.mem_we  = 1'b0;
            stb.ir_we   = 1'b0;
            stb.pc_we   = 1'b0;
            stb.rf_we   = 1'b0;
        end

        instret_d = instret_q + CNT_W'(stb.pc_we);
        cycles_d  = (state_q != ST_HALT) ? cycles_q + 1'b1 : cycles_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_FETCH;
            bus_err_q <= 1'b0;
            illegal_q <= 1'b0;
            instret_q <= '0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            bus_err_q <= bus_err_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
            cycles_q  <= cycles_d;
        end
    end

    assign mem_req  = stb.mem_req;
    assign mem_we   = stb.mem_we;
    assign addr_sel = stb.addr_sel;
    assign ir_we    = stb.ir_we;
    assign pc_we    = stb.pc_we;
    assign rf_we    = stb.rf_we;
    assign state    = state_q;
    assign halted   = (state_q == ST_HALT);
    assign bus_err  = bus_err_q;
    assign illegal  = illegal_q;
    assign instret  = instret_q;
    assign cycles   = cycles_q;

endmodule

// File: doc/mc_sequencer.md
# mc_sequencer

Multi-cycle control sequencer for the next-generation RV32 core, replacing the single-cycle, all-in-one-clock control flow. It steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over one shared, handshaked memory port with arbitrary wait states. It drives the PC, IR and register-file write enables for the existing datapath, and keeps retired-instruction and cycle counters. The block sits between the instruction register/decoder and the datapath enables.

## Interface
Parameters:
- CNT_W, 32, width of `instret` and `cycles` counters
- MEM_TIMEOUT, 16, max wait cycles per memory access before bus error (≥1)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- opcode  in  7  IR[6:0] of the latched instruction (valid from DECODE on)
- mem_ack  in  1  memory completes the transfer this cycle; sampled only while mem_req=1
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe, qualifies mem_req
- addr_sel  out  1  memory address source: 0 = PC, 1 = ALU result
- ir_we  out  1  load IR from memory read data
- pc_we  out  1  load PC from datapath next-PC
- rf_we  out  1  register-file write enable
- state  out  3  current state encoding
- halted  out  1  core stopped
- bus_err  out  1  sticky: memory timeout occurred
- illegal  out  1  sticky: unsupported opcode decoded
- instret  out  CNT_W  instructions retired
- cycles  out  CNT_W  clocks spent outside HALT

## Operation
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT.
- FETCH: mem_req=1, addr_sel=0, mem_we=0. On mem_ack: ir_we=1 in the same cycle, then go to DECODE. Otherwise stay in FETCH.
- DECODE: one cycle. Transitions:
  - ECALL/EBREAK (1110011) → HALT.
  - Any opcode not in {LOAD, STORE, OP, OP-IMM, LUI, AUIPC, JAL, JALR, BRANCH, FENCE} → HALT with illegal=1.
  - Otherwise → EXECUTE.
- EXECUTE: one cycle.
  - LOAD/STORE → MEMORY.
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR → WRITEBACK.
  - BRANCH, FENCE: pc_we=1 (retire), then → FETCH.
- MEMORY: mem_req=1, addr_sel=1, mem_we=1 for STORE.
  - LOAD on ack → WRITEBACK.
  - STORE on ack: pc_we=1 (retire), then → FETCH.
- WRITEBACK: rf_we=1, pc_we=1 (retire), then → FETCH.
- Retire cycle = the cycle pc_we=1. instret increments in that same cycle.
- cycles increments every clock while not in HALT and not in reset. Both counters wrap modulo 2^CNT_W.
- Timeout: the wait counter clears on entry to FETCH/MEMORY and on ack. It increments each cycle mem_req=1 without ack. When it reaches MEM_TIMEOUT: bus_err=1, state → HALT, no enable pulses that cycle.
- HALT: absorbing until reset. All strobes 0; mem_ack ignored.

## Timing
- Reset (rst=0 at an edge):
  - state=FETCH; halted, bus_err, illegal, instret, cycles = 0; wait counter = 0.
  - While rst=0, mem_req, mem_we, ir_we, pc_we and rf_we are forced to 0.
- Strobes are combinational from state, opcode and mem_ack. Each of ir_we, pc_we and rf_we is high for exactly one cycle per instruction at most.
- Zero-wait memory (ack in the first request cycle):
  - ALU/jump: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch/FENCE: 3 cycles.
- Each wait cycle adds one cycle to the FETCH or MEMORY state it occurs in.
- mem_req, mem_we and addr_sel stay stable from first assertion until the ack cycle.
- An ack arriving in the same cycle the wait counter hits MEM_TIMEOUT wins: the transfer completes and there is no error.
- Reset asserted mid-instruction (including during MEMORY with ack pending) aborts it with no retire and no rf_we. The first FETCH starts the cycle after rst returns high.
- halted = (state==HALT). It rises the cycle after the DECODE or timeout edge.

## Structure
- State encodings and opcode constants go in the shared defines file alongside the existing IR field macros.
- Sub-module: `wait_timer`, a parametrised saturating counter with clear/enable and a `expired` output at MEM_TIMEOUT. The sequencer instantiates it once.

## Test plan
- OP `add` with ack in every request cycle → FETCH, DECODE, EXECUTE, WRITEBACK; rf_we and pc_we high in cycle 4; instret=1; cycles=4.
- LW with ack delayed 2 cycles in MEMORY → 7 cycles total; addr_sel=1 throughout MEMORY; rf_we in cycle 7.
- SW, zero wait → mem_we=1 only in MEMORY; pc_we in cycle 4; rf_we never asserted.
- MEM_TIMEOUT=4, mem_ack held 0 in FETCH → after 4 request cycles: bus_err=1, halted=1; instret unchanged; cycles then freezes.
- Opcode 0x00 → HALT with illegal=1 after DECODE. ECALL (0x73) → HALT with illegal=0.
- rst=0 during a pending MEMORY access of a LW → next cycle state=FETCH, counters=0, no rf_we; normal fetch resumes after rst=1.
